dm_arbiter: RTL

//  Shares the single byte-addressed data memory between two requesters: port 0 (CPU MEM stage) and port 1 (program/data loader).

---
 rtl/dm_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the byte-addressed data memory: one access every
// two cycles (IDLE grant/latch, ISSUE drive), with legality screening and a starvation guard.
module dm_arbiter #(
    parameter int unsigned MEM_BYTES    = 32768,
    parameter int unsigned PRIO_MODE    = 0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [2:0]  p0_type,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [2:0]  p1_type,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  DMType,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam int unsigned     SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [32:0]     MEM_LIMIT  = 33'(MEM_BYTES);
    localparam logic            USE_STARVE = (STARVE_LIMIT != 0);
    localparam logic            USE_RR     = (PRIO_MODE != 0);

    function automatic logic [2:0] access_size(input logic [1:0] code);
        case (code)
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            2'b10:   access_size = 3'd4;
            default: access_size = 3'd0;
        endcase
    endfunction

    // 33-bit end address so accesses near 4 GiB cannot wrap back into range.
    function automatic logic access_legal(input logic [1:0] code, input logic [31:0] addr);
        logic [32:0] end_addr;
        end_addr     = {1'b0, addr} + {30'd0, access_size(code)};
        access_legal = (code != 2'b11) && (end_addr <= MEM_LIMIT);
    endfunction

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic [2:0]    type_q, type_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          legal_q, legal_d;
    logic          p0_done_q, p0_done_d;
    logic          p1_done_q, p1_done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          pref_q, pref_d;
    logic          win_p1_s;
    logic          gnt0_s;
    logic          gnt1_s;

    // Pick the winner assuming the arbiter is idle; meaningful only when a request is present.
    always_comb begin
        win_p1_s = 1'b0;
        if (p0_req && p1_req) begin
            if (USE_STARVE && (starve_q == STARVE_MAX)) begin
                win_p1_s = 1'b1;
            end else if (USE_RR) begin
                win_p1_s = pref_q;
            end else begin
                win_p1_s = 1'b0;
            end
        end else begin
            win_p1_s = p1_req;
        end
    end

    // Next-state, latch and completion logic for the IDLE/ISSUE sequencer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        type_d    = type_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        legal_d   = legal_q;
        p0_done_d = 1'b0;
        p1_done_d = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        starve_d  = starve_q;
        pref_d    = pref_q;
        gnt0_s    = 1'b0;
        gnt1_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    gnt0_s  = ~win_p1_s;
                    gnt1_s  = win_p1_s;
                    owner_d = win_p1_s;
                    pref_d  = ~win_p1_s;
                    state_d = ST_ISSUE;
                    if (win_p1_s) begin
                        we_d    = p1_we;
                        type_d  = p1_type;
                        addr_d  = p1_addr;
                        wdata_d = p1_wdata;
                        legal_d = access_legal(p1_type[1:0], p1_addr);
                    end else begin
                        we_d    = p0_we;
                        type_d  = p0_type;
                        addr_d  = p0_addr;
                        wdata_d = p0_wdata;
                        legal_d = access_legal(p0_type[1:0], p0_addr);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
                // Port 1 only accumulates losses while it is actually waiting.
                if (!p1_req || win_p1_s) begin
                    starve_d = {SW{1'b0}};
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = starve_q;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_IDLE;
                p0_done_d = ~owner_q;
                p1_done_d = owner_q;
                err_d     = ~legal_q;
                if (legal_q && !we_q) begin
                    rdata_d = Read_data;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            type_q    <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            legal_q   <= 1'b0;
            p0_done_q <= 1'b0;
            p1_done_q <= 1'b0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            starve_q  <= {SW{1'b0}};
            pref_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            type_q    <= type_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            legal_q   <= legal_d;
            p0_done_q <= p0_done_d;
            p1_done_q <= p1_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            starve_q  <= starve_d;
            pref_q    <= pref_d;
        end
    end

    // Strobes are gated by rstn so a reset landing mid-ISSUE never commits a store.
    assign p0_gnt     = gnt0_s & rstn;
    assign p1_gnt     = gnt1_s & rstn;
    assign MemRead    = rstn & (state_q == ST_ISSUE) & legal_q & ~we_q;
    assign MemWrite   = rstn & (state_q == ST_ISSUE) & legal_q & we_q;
    assign DMType     = type_q;
    assign Address    = addr_q;
    assign Write_data = wdata_q;
    assign p0_done    = p0_done_q;
    assign p1_done    = p1_done_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

endmodule
